// File: rtl/instruction_prefetch_queue.sv
// Fetch-side prefetch buffer: issues sequential word fetches over a req/ack port
// and queues up to DEPTH {PC, instruction} entries for the IF/ID register.
module instruction_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_data,
  output logic                         inst_valid,
  output logic [31:0]                  instruction,
  output logic [31:0]                  inst_pc,
  output logic [31:0]                  inst_next_address,
  input  logic                         inst_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic [31:0]      target_pc;
  logic [31:0]      issue_addr;
  logic [CNT_W-1:0] count_post;
  logic             take, write, issue;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // A redirect overrides both queue write and take in the same cycle
  always_comb begin
    take       = !redirect && inst_take && (count != '0);
    write      = !redirect && (state == S_WAIT) && mem_ack;
    count_post = count + CNT_W'(write) - CNT_W'(take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = fetch_pc;
    case (state)
      S_IDLE: begin
        if (redirect) begin
          state_nxt  = S_WAIT;
          issue      = 1'b1;
          issue_addr = target_pc;
        end else if (count < FULL) begin
          state_nxt = S_WAIT;
          issue     = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (mem_ack) begin
            issue      = 1'b1;
            issue_addr = target_pc;
          end else begin
            state_nxt = S_DISCARD;
          end
        end else if (mem_ack) begin
          // Only request again when a slot is still free after this write
          if (count_post < FULL) issue = 1'b1;
          else                   state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (!redirect && mem_ack) begin
          state_nxt = S_WAIT;
          issue     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        mem_addr <= issue_addr;
        fetch_pc <= issue_addr + 32'd4;
      end else if (redirect) begin
        fetch_pc <= target_pc;
      end
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (write) tail <= tail + PTR_W'(1);
        if (take)  head <= head + PTR_W'(1);
        count <= count_post;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      pc_mem[tail]   <= mem_addr;
      inst_mem[tail] <= mem_data;
    end
  end

  always_comb begin
    inst_valid        = (count != '0);
    instruction       = inst_valid ? inst_mem[head] : 32'd0;
    inst_pc           = inst_valid ? pc_mem[head]   : 32'd0;
    inst_next_address = inst_pc + 32'd4;
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect, mem_req, mem_ack, inst_valid, inst_take;
  logic [31:0] redirect_pc, mem_addr, mem_data, instruction, inst_pc, inst_next_address;
  logic [$clog2(DEPTH+1)-1:0] count;

  always #5 clk = ~clk;

  instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc),
    .inst_next_address(inst_next_address), .inst_take(inst_take), .count(count)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  bit          m_req, m_disc, started;
  logic [31:0] m_addr, m_fetch;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_req   = 1'b0;
    m_disc  = 1'b0;
    m_addr  = RESET_PC;
    m_fetch = RESET_PC;
  endfunction

  // One clock edge of the reference behaviour, from the inputs applied before it
  function automatic void model_step();
    int sz;
    if (rst) begin
      model_reset();
      return;
    end
    sz = mq.size();
    if (redirect) begin
      mq.delete();
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
      if (!m_req || (!m_disc && mem_ack)) begin
        m_req   = 1'b1;
        m_disc  = 1'b0;
        m_addr  = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end else begin
        m_disc = 1'b1;
      end
      return;
    end
    if (inst_take && sz > 0) void'(mq.pop_front());
    if (m_req && mem_ack) begin
      if (m_disc) begin
        m_disc  = 1'b0;
        m_addr  = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end else begin
        mq.push_back('{m_addr, mem_data});
        if (mq.size() < DEPTH) begin
          m_addr  = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end else begin
          m_req = 1'b0;
        end
      end
    end else if (!m_req && sz < DEPTH) begin
      m_req   = 1'b1;
      m_addr  = m_fetch;
      m_fetch = m_fetch + 32'd4;
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("mem_req", mem_req, m_req);
      chk("mem_addr", mem_addr, m_addr);
      chk("count", 32'(count), 32'(mq.size()));
      chk("inst_valid", inst_valid, 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instruction", instruction, mq[0].ins);
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst_next_address", inst_next_address, mq[0].pc + 32'd4);
      end else begin
        chk("instruction_empty", instruction, 32'd0);
        chk("inst_pc_empty", inst_pc, 32'd0);
        chk("inst_next_address_empty", inst_next_address, 32'd4);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] rp, input logic a, input logic t);
    redirect    = r;
    redirect_pc = rp;
    mem_ack     = a;
    inst_take   = t;
    mem_data    = $urandom;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    started = 1'b1;
    #1;
    chk("rst_req_drop", mem_req, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b0; inst_take = 1'b0; mem_data = '0;
    started = 1'b0;
    #1;

    // Streaming: ack every cycle, take every cycle
    do_reset();
    chk("rst_next_addr", inst_next_address, 32'h4);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_count", 32'(count), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("s1_first_addr", mem_addr, 32'h0);
    chk("s1_first_req", mem_req, 32'd1);
    chk("s1_first_valid", inst_valid, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      chk("s1_pc", inst_pc, 32'(4 * k));
      chk("s1_addr", mem_addr, 32'(4 * k + 4));
      chk("s1_count_le1", 32'(count <= 1), 32'd1);
    end

    // Fill to DEPTH with no takes, then one take re-opens fetch
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s2_count_full", 32'(count), 32'd4);
    chk("s2_req_off", mem_req, 32'd0);
    chk("s2_head_pc", inst_pc, 32'h0);
    chk("s2_model_tail_pc", mq[3].pc, 32'hC);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("s2_count_after_take", 32'(count), 32'd3);
    chk("s2_head_after_take", inst_pc, 32'h4);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("s2_reissue_req", mem_req, 32'd1);
    chk("s2_reissue_addr", mem_addr, 32'h10);

    // Redirect while a delayed ack is outstanding
    do_reset();
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s3_count_pre", 32'(count), 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b0, 1'b0);
    chk("s3_flush_count", 32'(count), 32'd0);
    chk("s3_flush_valid", inst_valid, 32'd0);
    chk("s3_held_addr", mem_addr, 32'h8);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s3_dropped_count", 32'(count), 32'd0);
    chk("s3_target_addr", mem_addr, 32'h100);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s3_first_pc", inst_pc, 32'h100);
    chk("s3_first_ins", instruction, mem_data);

    // Redirect, ack and take together with two entries queued
    do_reset();
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s4_count_pre", 32'(count), 32'd2);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    chk("s4_count", 32'(count), 32'd0);
    chk("s4_valid", inst_valid, 32'd0);
    chk("s4_req", mem_req, 32'd1);
    chk("s4_addr", mem_addr, 32'h2000);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s4_pc", inst_pc, 32'h2000);

    // Address wrap at the top of the 32-bit space
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
    chk("s5_addr0", mem_addr, 32'hFFFF_FFF8);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s5_addr1", mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s5_addr2", mem_addr, 32'h0);
    chk("s5_count", 32'(count), 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("s5_pc", inst_pc, 32'hFFFF_FFFC);
    chk("s5_next_wrap", inst_next_address, 32'h0);

    // Reset in the middle of a request, followed by a stale ack
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("s6_req_drop", mem_req, 32'd0);
    chk("s6_count_clear", 32'(count), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_req", mem_req, 32'd1);
    chk("s6_addr", mem_addr, RESET_PC);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
